// File: rtl/video_out_gen.sv
// Turns latched palette colour codes into a 12-phase composite DAC level stream with sync, burst and blanking.
// Two registered stages: pixel latch on PCLK_EN, then the sample register that is updated on every CLK.
module video_out_gen #(
    parameter int PHASES    = 12,
    parameter int BURST_HUE = 8,
    parameter int BURST_LL  = 0
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       PCLK_EN,
    input  logic [3:0] n_CC,
    input  logic [1:0] n_LL,
    input  logic       SYNC,
    input  logic       BURST,
    input  logic       BLACK,
    input  logic       TR,
    input  logic       TG,
    input  logic       TB,
    output logic [3:0] VOUT,
    output logic       EMPH_ATT,
    output logic [3:0] PHASE
);

    localparam logic [3:0] LAST_PH = 4'(PHASES - 1);
    localparam logic [3:0] B_HUE   = 4'(BURST_HUE);
    localparam logic [1:0] B_LL    = 2'(BURST_LL);

    typedef struct packed {
        logic [3:0] h;
        logic [1:0] ll;
        logic       sync;
        logic       burst;
        logic       black;
        logic       tr;
        logic       tg;
        logic       tb;
    } px_t;

    localparam px_t PX_RESET = '{h: 4'd0, ll: 2'd0, sync: 1'b0, burst: 1'b0,
                                 black: 1'b1, tr: 1'b0, tg: 1'b0, tb: 1'b0};

    px_t        px_q, px_d;
    logic [3:0] ph_q, ph_d;
    logic [3:0] vout_q, vout_d;
    logic       emph_q, emph_d;
    logic [3:0] phase_q;

    // Six-phase-wide chroma window for hue h (1..12) at subcarrier phase p.
    function automatic logic win(input logic [3:0] h, input logic [3:0] p);
        logic [4:0] d;
        d = {1'b0, p} + 5'd13 - {1'b0, h};
        if (d >= 5'd12) begin
            d = d - 5'd12;
        end
        return d < 5'd6;
    endfunction

    always_comb begin
        ph_d   = (ph_q == LAST_PH) ? 4'd0 : ph_q + 4'd1;
        px_d   = px_q;
        vout_d = 4'd1;
        emph_d = 1'b0;

        if (PCLK_EN) begin
            px_d = '{h: ~n_CC, ll: ~n_LL, sync: SYNC, burst: BURST,
                     black: BLACK, tr: TR, tg: TG, tb: TB};
        end

        if (px_q.sync) begin
            vout_d = 4'd0;
        end else if (px_q.burst) begin
            vout_d = 4'd2 + {1'b0, B_LL, win(B_HUE, ph_q)};
        end else if (!px_q.black && px_q.h <= 4'd13) begin
            unique case (px_q.h)
                4'd0:    vout_d = 4'd2 + {1'b0, px_q.ll, 1'b1};
                4'd13:   vout_d = 4'd2 + {1'b0, px_q.ll, 1'b0};
                default: vout_d = 4'd2 + {1'b0, px_q.ll, win(px_q.h, ph_q)};
            endcase
            emph_d = (px_q.tr & win(4'd12, ph_q)) |
                     (px_q.tg & win(4'd4,  ph_q)) |
                     (px_q.tb & win(4'd8,  ph_q));
        end
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            ph_q    <= 4'd0;
            px_q    <= PX_RESET;
            vout_q  <= 4'd1;
            emph_q  <= 1'b0;
            phase_q <= 4'd0;
        end else begin
            ph_q    <= ph_d;
            px_q    <= px_d;
            vout_q  <= vout_d;
            emph_q  <= emph_d;
            phase_q <= ph_q;
        end
    end

    assign VOUT     = vout_q;
    assign EMPH_ATT = emph_q;
    assign PHASE    = phase_q;

endmodule
